fifo_uart_tx: RTL and testbench

//  Drains bytes from the pop side of an FPGA_FIFO read port and serializes

---
 rtl/fifo_uart_tx.sv | 118 +++++++++++
 tb/tb_fifo_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter fed from the pop side of a FIFO read port.
// One byte is popped per frame; the line, busy and done outputs are registered.
module fifo_uart_tx #(
  parameter int DIV_W   = 16,
  parameter int POP_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Tx_En,
  input  logic [DIV_W-1:0] Baud_Div,
  input  logic             Fifo_Empty,
  output logic             Fifo_Pop,
  input  logic [7:0]       Fifo_Dout,
  output logic             Tx_Out,
  output logic             Tx_Busy,
  output logic             Byte_Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] WAIT_CNT = DIV_W'(POP_LAT - 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             tx_q;
  logic             done_q;
  logic             cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign Tx_Out    = tx_q;
  assign Byte_Done = done_q;
  assign Tx_Busy   = (state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    Fifo_Pop = 1'b0;
    case (state)
      S_IDLE:  if (Tx_En && !Fifo_Empty) state_n = S_POP;
      S_POP: begin
        Fifo_Pop = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT:  if (cnt_zero) state_n = S_START;
      S_START: if (cnt_zero) state_n = S_DATA;
      S_DATA:  if (cnt_zero && bit_cnt == 3'd7) state_n = S_STOP;
      S_STOP:  if (cnt_zero) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // The line and done pulse are registered off the current state, so both
  // lag the state by one cycle and stay aligned with each other.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      div_q   <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == S_STOP) && cnt_zero;
      case (state)
        S_START: tx_q <= 1'b0;
        S_DATA:  tx_q <= shift[0];
        default: tx_q <= 1'b1;
      endcase

      case (state)
        S_POP: cnt <= WAIT_CNT;
        S_WAIT: begin
          if (cnt_zero) begin
            shift   <= Fifo_Dout;
            div_q   <= Baud_Div;
            cnt     <= Baud_Div;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_START: begin
          if (cnt_zero) cnt <= div_q;
          else          cnt <= cnt - ONE;
        end
        S_DATA: begin
          if (cnt_zero) begin
            cnt     <= div_q;
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_STOP: begin
          if (!cnt_zero) cnt <= cnt - ONE;
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized checks of fifo_uart_tx against a FIFO model and
// an expected-waveform model built from the 8N1 frame rules.
module tb_fifo_uart_tx;
  localparam int DIV_W   = 16;
  localparam int POP_LAT = 1;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Tx_En;
  logic [DIV_W-1:0] Baud_Div;
  logic             Fifo_Empty;
  logic             Fifo_Pop;
  logic [7:0]       Fifo_Dout;
  logic             Tx_Out;
  logic             Tx_Busy;
  logic             Byte_Done;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pops = 0;
  int         pend_cyc = -1;
  logic [7:0] pend_data = 8'h00;
  logic [7:0] q[$];

  always #5 Clk = ~Clk;

  fifo_uart_tx #(.DIV_W(DIV_W), .POP_LAT(POP_LAT)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Tx_En     (Tx_En),
    .Baud_Div  (Baud_Div),
    .Fifo_Empty(Fifo_Empty),
    .Fifo_Pop  (Fifo_Pop),
    .Fifo_Dout (Fifo_Dout),
    .Tx_Out    (Tx_Out),
    .Tx_Busy   (Tx_Busy),
    .Byte_Done (Byte_Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and advance the FIFO model.
  // Read data is valid only on the cycle POP_LAT after the pop; junk otherwise.
  task automatic step();
    @(negedge Clk);
    cyc++;
    if (Fifo_Pop === 1'b1) begin
      chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
      pops++;
      if (q.size() != 0) pend_data = q.pop_front();
      pend_cyc = cyc + POP_LAT;
    end
    Fifo_Dout  = (cyc == pend_cyc) ? pend_data : 8'($urandom);
    Fifo_Empty = (q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    Fifo_Empty = 1'b0;
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (Tx_Out !== 1'b0 && n < lim) begin
      step();
      n++;
    end
    chk("start_seen", 32'(Tx_Out), 32'd0);
  endtask

  // Expected line: start 0, data LSB first, stop 1; each bit div+1 cycles.
  // Byte_Done only on the final stop cycle. Optionally change Baud_Div at
  // frame cycle chg_at to show it has no effect mid-frame.
  task automatic expect_frame(input logic [7:0] b, input int div,
                              input int chg_at, input int chg_div);
    int   k;
    logic bitv;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bitv = 1'b0;
      else if (i == 9) bitv = 1'b1;
      else             bitv = b[i-1];
      for (int j = 0; j <= div; j++) begin
        if (k > 0) step();
        if (k == chg_at) Baud_Div = DIV_W'(chg_div);
        chk("tx_bit", 32'(Tx_Out), 32'(bitv));
        chk("byte_done", 32'(Byte_Done), 32'(i == 9 && j == div));
        k++;
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, {29'd0, Fifo_Pop, Tx_Out, Tx_Busy}, 32'b010);
    end
  endtask

  initial begin
    int         n;
    int         p0;
    int         div;
    int         cnt;
    logic [7:0] bytes[$];

    Rst        = 1'b1;
    Tx_En      = 1'b0;
    Baud_Div   = DIV_W'(3);
    Fifo_Empty = 1'b1;
    Fifo_Dout  = 8'h00;
    repeat (3) step();
    chk("rst_state", {28'd0, Fifo_Pop, Tx_Out, Tx_Busy, Byte_Done}, 32'b0100);
    Rst = 1'b0;
    step();
    chk("post_rst", {28'd0, Fifo_Pop, Tx_Out, Tx_Busy, Byte_Done}, 32'b0100);

    // Empty FIFO with transmission enabled: nothing happens.
    Tx_En = 1'b1;
    idle_check(100, "empty_idle");

    // Single byte 0xA5 at 4 clks/bit.
    p0 = pops;
    push(8'hA5);
    wait_start(20, n);
    expect_frame(8'hA5, 3, -1, 0);
    idle_check(20, "after_a5");
    chk("a5_pops", 32'(pops - p0), 32'd1);

    // Back-to-back frames at 1 clk/bit; gap is IDLE, POP, WAIT.
    Baud_Div = DIV_W'(0);
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    wait_start(20, n);
    expect_frame(8'h00, 0, -1, 0);
    wait_start(20, n);
    chk("gap_len", 32'(n), 32'(3 + POP_LAT));
    expect_frame(8'hFF, 0, -1, 0);
    idle_check(10, "after_00ff");
    chk("00ff_pops", 32'(pops - p0), 32'd2);

    // Reset during data bit 3 of 0x55 aborts the frame at once.
    Baud_Div = DIV_W'(3);
    p0 = pops;
    push(8'h55);
    wait_start(20, n);
    repeat (17) step();
    chk("mid_bit3", 32'(Tx_Out), 32'd0);
    Rst = 1'b1;
    step();
    chk("abort_line", {30'd0, Tx_Out, Tx_Busy}, 32'b10);
    push(8'h5A);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_nopop", {30'd0, Fifo_Pop, Tx_Out}, 32'b01);
    end
    Rst = 1'b0;
    wait_start(20, n);
    expect_frame(8'h5A, 3, -1, 0);
    chk("rst_pops", 32'(pops - p0), 32'd2);

    // Disable during START: frame completes, then no further pop.
    p0 = pops;
    push(8'h3C);
    push(8'h11);
    wait_start(20, n);
    Tx_En = 1'b0;
    expect_frame(8'h3C, 3, -1, 0);
    idle_check(60, "disabled_idle");
    chk("dis_pops", 32'(pops - p0), 32'd1);
    Tx_En = 1'b1;
    wait_start(20, n);
    expect_frame(8'h11, 3, -1, 0);

    // Divisor change mid-frame only takes effect on the next frame.
    p0 = pops;
    push(8'hC3);
    push(8'h96);
    wait_start(20, n);
    expect_frame(8'hC3, 3, 9, 7);
    wait_start(20, n);
    chk("gap_div", 32'(n), 32'(3 + POP_LAT));
    expect_frame(8'h96, 7, -1, 0);
    chk("div_pops", 32'(pops - p0), 32'd2);

    // Random bursts at random divisors.
    for (int r = 0; r < 6; r++) begin
      idle_check(3, "rnd_idle");
      div = $urandom_range(0, 5);
      Baud_Div = DIV_W'(div);
      cnt = $urandom_range(1, 3);
      bytes.delete();
      p0 = pops;
      for (int i = 0; i < cnt; i++) begin
        bytes.push_back(8'($urandom));
        push(bytes[i]);
      end
      for (int i = 0; i < cnt; i++) begin
        wait_start(20, n);
        if (i > 0) chk("rnd_gap", 32'(n), 32'(3 + POP_LAT));
        expect_frame(bytes[i], div, -1, 0);
      end
      chk("rnd_pops", 32'(pops - p0), 32'(cnt));
    end
    idle_check(10, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
